pipeline_hazard_ctrl: RTL and testbench

Central hazard controller for the 5-stage pipeline (IF, ID, EX, MEM, WB). It generates the registered forwarding selects consumed by the EX-stage operand mux. It drives the enable (stall) and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB buffers. It sequences load-use bubbles, taken-branch flushes and memory-wait freezes with a small FSM.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 33 +++
 rtl/pipeline_hazard_ctrl_if.sv | 48 ++++
 rtl/pipeline_hazard_ctrl_forward_select.sv | 31 +++
 rtl/pipeline_hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the 5-stage pipeline hazard controller: FSM states,
// EX operand-select codes and the bundled buffer enable/flush word.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MEM_WAIT   = 2'd3
    } hz_state_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REG    = 2'b00;
    localparam fwd_sel_t FWD_ALUOUT = 2'b01;
    localparam fwd_sel_t FWD_RESULT = 2'b10;

    typedef struct packed {
        logic en_if;
        logic en_id;
        logic en_ex;
        logic en_mem;
        logic flush_id;
        logic flush_ex;
        logic flush_mem;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_NORMAL   = 7'b1111_000;
    localparam hz_ctrl_t CTRL_LOAD_USE = 7'b0011_010;
    localparam hz_ctrl_t CTRL_BRANCH   = 7'b1111_111;
    localparam hz_ctrl_t CTRL_FREEZE   = 7'b0000_000;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline-stage status in, forwarding selects,
// buffer enables/flushes and performance counters out.
interface pipeline_hazard_ctrl_if #(
    parameter int RW = 4,
    parameter int CW = 16
);

    logic          id_valid;
    logic [RW-1:0] id_ra;
    logic [RW-1:0] id_rb;
    logic          id_uses_rb;
    logic [RW-1:0] ex_rd;
    logic          ex_regWrite;
    logic          ex_memToReg;
    logic [RW-1:0] mem_rd;
    logic          mem_regWrite;
    logic          branch_taken;
    logic          mem_busy;

    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic          en_if;
    logic          en_id;
    logic          en_ex;
    logic          en_mem;
    logic          flush_id;
    logic          flush_ex;
    logic          flush_mem;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    modport master (
        output id_valid, id_ra, id_rb, id_uses_rb,
        output ex_rd, ex_regWrite, ex_memToReg,
        output mem_rd, mem_regWrite, branch_taken, mem_busy,
        input  fwd_a, fwd_b, en_if, en_id, en_ex, en_mem,
        input  flush_id, flush_ex, flush_mem, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_ra, id_rb, id_uses_rb,
        input  ex_rd, ex_regWrite, ex_memToReg,
        input  mem_rd, mem_regWrite, branch_taken, mem_busy,
        output fwd_a, fwd_b, en_if, en_id, en_ex, en_mem,
        output flush_id, flush_ex, flush_mem, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_forward_select.sv
// Forwarding decision for one EX source operand: the youngest in-flight
// writer (EX before MEM) of the source register supplies the value.
module forward_select
    import pipe_ctrl_pkg::*;
#(
    parameter int RW      = 4,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic [RW-1:0] i_src,
    input  logic          i_src_used,
    input  logic [RW-1:0] i_ex_rd,
    input  logic          i_ex_reg_write,
    input  logic [RW-1:0] i_mem_rd,
    input  logic          i_mem_reg_write,
    output fwd_sel_t      o_sel
);

    logic w_src_live;

    assign w_src_live = i_src_used && !(R0_ZERO && (i_src == '0));

    always_comb begin
        o_sel = FWD_REG;
        if (w_src_live && i_ex_reg_write && (i_ex_rd == i_src)) begin
            o_sel = FWD_ALUOUT;
        end else if (w_src_live && i_mem_reg_write && (i_mem_rd == i_src)) begin
            o_sel = FWD_RESULT;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller: registered EX forwarding selects plus the FSM
// sequencing load-use bubbles, branch flushes and memory-wait freezes.
// Optional saturating stall/flush counters: define PIPE_PERF_CNT_EN.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RW      = 4,
    parameter bit R0_ZERO = 1'b1,
    parameter int CW      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  bus
);

    hz_state_t r_state;
    hz_state_t w_state_nxt;
    logic      r_branch_pend;
    logic      w_branch_pend_nxt;
    hz_ctrl_t  w_ctrl;
    fwd_sel_t  r_fwd_a;
    fwd_sel_t  r_fwd_b;
    fwd_sel_t  w_sel_a;
    fwd_sel_t  w_sel_b;
    logic      w_load_use;

    forward_select #(.RW(RW), .R0_ZERO(R0_ZERO)) u_fwd_a (
        .i_src          (bus.id_ra),
        .i_src_used     (1'b1),
        .i_ex_rd        (bus.ex_rd),
        .i_ex_reg_write (bus.ex_regWrite),
        .i_mem_rd       (bus.mem_rd),
        .i_mem_reg_write(bus.mem_regWrite),
        .o_sel          (w_sel_a)
    );

    forward_select #(.RW(RW), .R0_ZERO(R0_ZERO)) u_fwd_b (
        .i_src          (bus.id_rb),
        .i_src_used     (bus.id_uses_rb),
        .i_ex_rd        (bus.ex_rd),
        .i_ex_reg_write (bus.ex_regWrite),
        .i_mem_rd       (bus.mem_rd),
        .i_mem_reg_write(bus.mem_regWrite),
        .o_sel          (w_sel_b)
    );

    assign w_load_use = bus.id_valid && bus.ex_regWrite && bus.ex_memToReg
                     && !(R0_ZERO && (bus.ex_rd == '0))
                     && ((bus.ex_rd == bus.id_ra)
                         || (bus.id_uses_rb && (bus.ex_rd == bus.id_rb)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= RUN;
            r_branch_pend <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_branch_pend <= w_branch_pend_nxt;
        end
    end

    // mem_busy overrides every state; a branch seen while frozen is remembered
    // and replayed as the flush pattern in the FLUSH cycle after the wait.
    always_comb begin
        w_ctrl            = CTRL_NORMAL;
        w_state_nxt       = r_state;
        w_branch_pend_nxt = r_branch_pend;
        if (!rst) begin
            w_state_nxt       = RUN;
            w_branch_pend_nxt = 1'b0;
        end else if (bus.mem_busy) begin
            w_ctrl            = CTRL_FREEZE;
            w_state_nxt       = MEM_WAIT;
            w_branch_pend_nxt = r_branch_pend | bus.branch_taken;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (bus.branch_taken) begin
                        w_ctrl      = CTRL_BRANCH;
                        w_state_nxt = FLUSH;
                    end else if (w_load_use) begin
                        w_ctrl      = CTRL_LOAD_USE;
                        w_state_nxt = LOAD_STALL;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end
                LOAD_STALL: begin
                    if (bus.branch_taken) begin
                        w_ctrl      = CTRL_BRANCH;
                        w_state_nxt = FLUSH;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end
                FLUSH: begin
                    if (r_branch_pend) begin
                        w_ctrl = CTRL_BRANCH;
                    end
                    w_branch_pend_nxt = 1'b0;
                    w_state_nxt       = RUN;
                end
                MEM_WAIT: begin
                    w_branch_pend_nxt = r_branch_pend | bus.branch_taken;
                    w_state_nxt       = (r_branch_pend || bus.branch_taken) ? FLUSH : RUN;
                end
                default: begin
                    w_state_nxt = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fwd_a <= FWD_REG;
            r_fwd_b <= FWD_REG;
        end else if (w_ctrl.en_ex) begin
            r_fwd_a <= w_ctrl.flush_ex ? FWD_REG : w_sel_a;
            r_fwd_b <= w_ctrl.flush_ex ? FWD_REG : w_sel_b;
        end
    end

    assign bus.fwd_a     = r_fwd_a;
    assign bus.fwd_b     = r_fwd_b;
    assign bus.en_if     = w_ctrl.en_if;
    assign bus.en_id     = w_ctrl.en_id;
    assign bus.en_ex     = w_ctrl.en_ex;
    assign bus.en_mem    = w_ctrl.en_mem;
    assign bus.flush_id  = w_ctrl.flush_id;
    assign bus.flush_ex  = w_ctrl.flush_ex;
    assign bus.flush_mem = w_ctrl.flush_mem;

`ifdef PIPE_PERF_CNT_EN
    logic [CW-1:0] r_stall_cnt;
    logic [CW-1:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_ctrl.en_if && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CW'(1);
            end
            if (w_ctrl.flush_id && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CW'(1);
            end
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
`else
    assign bus.stall_cnt = '0;
    assign bus.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: each cycle's expected outputs
// are queued as the stimulus is applied and compared mid-cycle.
module tb_pipeline_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.RW(4), .CW(16)) bus ();

    pipeline_hazard_ctrl #(.RW(4), .R0_ZERO(1'b1), .CW(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {en_if, en_id, en_ex, en_mem, flush_id, flush_ex, flush_mem}
    localparam logic [6:0] NRM = 7'b1111_000;
    localparam logic [6:0] LU  = 7'b0011_010;
    localparam logic [6:0] BRF = 7'b1111_111;
    localparam logic [6:0] FRZ = 7'b0000_000;

    typedef struct packed {
        logic       valid;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       urb;
        logic [3:0] exrd;
        logic       exrw;
        logic       exm2r;
        logic [3:0] memrd;
        logic       memrw;
        logic       br;
        logic       busy;
    } stim_t;

    typedef struct {
        string       name;
        logic [10:0] v;
    } exp_t;

    typedef struct {
        stim_t       s;
        logic [10:0] e;
    } row_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    localparam stim_t IDLE = '0;

    function automatic stim_t st(input logic v, input logic [3:0] ra, input logic [3:0] rb,
                                 input logic urb, input logic [3:0] exrd, input logic exrw,
                                 input logic exm2r, input logic [3:0] memrd, input logic memrw,
                                 input logic br, input logic busy);
        return '{v, ra, rb, urb, exrd, exrw, exm2r, memrd, memrw, br, busy};
    endfunction

    function automatic logic [10:0] ex(input logic [1:0] fa, input logic [1:0] fb, input logic [6:0] c);
        return {fa, fb, c};
    endfunction

    function automatic logic [10:0] obs();
        return {bus.fwd_a, bus.fwd_b, bus.en_if, bus.en_id, bus.en_ex, bus.en_mem,
                bus.flush_id, bus.flush_ex, bus.flush_mem};
    endfunction

    task automatic apply(input stim_t s);
        bus.id_valid     = s.valid;
        bus.id_ra        = s.ra;
        bus.id_rb        = s.rb;
        bus.id_uses_rb   = s.urb;
        bus.ex_rd        = s.exrd;
        bus.ex_regWrite  = s.exrw;
        bus.ex_memToReg  = s.exm2r;
        bus.mem_rd       = s.memrd;
        bus.mem_regWrite = s.memrw;
        bus.branch_taken = s.br;
        bus.mem_busy     = s.busy;
    endtask

    task automatic note(input logic [10:0] e);
        if (!e[6]) exp_stall++;
        if (e[2])  exp_flush++;
    endtask

    task automatic test_reset();
        exp_t e;
        apply(st(1, 2, 2, 1, 2, 1, 1, 2, 1, 1, 0));
        #2;
        sb.push_back('{"reset", ex(2'b00, 2'b00, NRM)});
        e = sb.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s got %b exp %b", e.name, obs(), e.v);
        end
        checks++;
        if ({bus.stall_cnt, bus.flush_cnt} !== 32'd0) begin
            errors++;
            $display("FAIL reset_cnt got %h exp 0", {bus.stall_cnt, bus.flush_cnt});
        end
        apply(IDLE);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fwd_ex();
        row_t rows[$];
        exp_t e;
        rows.push_back('{st(1, 3, 0, 0, 3, 1, 0, 0, 0, 0, 0), ex(2'b00, 2'b00, NRM)});
        rows.push_back('{IDLE, ex(2'b01, 2'b00, NRM)});
        rows.push_back('{IDLE, ex(2'b00, 2'b00, NRM)});
        foreach (rows[i]) begin
            @(posedge clk); #1;
            apply(rows[i].s);
            sb.push_back('{$sformatf("fwd_ex[%0d]", i), rows[i].e});
            note(rows[i].e);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.v) begin
                errors++;
                $display("FAIL %s got %b exp %b", e.name, obs(), e.v);
            end
        end
    endtask

    task automatic test_fwd_priority();
        row_t rows[$];
        exp_t e;
        rows.push_back('{st(1, 0, 5, 1, 5, 1, 0, 5, 1, 0, 0), ex(2'b00, 2'b00, NRM)});
        rows.push_back('{st(1, 0, 5, 0, 5, 1, 0, 5, 1, 0, 0), ex(2'b00, 2'b01, NRM)});
        rows.push_back('{st(1, 7, 0, 0, 0, 0, 0, 7, 1, 0, 0), ex(2'b00, 2'b00, NRM)});
        rows.push_back('{IDLE, ex(2'b10, 2'b00, NRM)});
        rows.push_back('{IDLE, ex(2'b00, 2'b00, NRM)});
        foreach (rows[i]) begin
            @(posedge clk); #1;
            apply(rows[i].s);
            sb.push_back('{$sformatf("fwd_prio[%0d]", i), rows[i].e});
            note(rows[i].e);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.v) begin
                errors++;
                $display("FAIL %s got %b exp %b", e.name, obs(), e.v);
            end
        end
    endtask

    task automatic test_load_use();
        row_t rows[$];
        exp_t e;
        logic [15:0] xs;
        rows.push_back('{st(1, 2, 0, 0, 2, 1, 1, 0, 0, 0, 0), ex(2'b00, 2'b00, LU)});
        rows.push_back('{st(1, 2, 0, 0, 2, 1, 1, 0, 0, 0, 0), ex(2'b00, 2'b00, NRM)});
        rows.push_back('{IDLE, ex(2'b01, 2'b00, NRM)});
        rows.push_back('{IDLE, ex(2'b00, 2'b00, NRM)});
        rows.push_back('{st(1, 9, 4, 1, 4, 1, 1, 0, 0, 0, 0), ex(2'b00, 2'b00, LU)});
        rows.push_back('{IDLE, ex(2'b00, 2'b00, NRM)});
        rows.push_back('{st(1, 9, 4, 0, 4, 1, 1, 0, 0, 0, 0), ex(2'b00, 2'b00, NRM)});
        rows.push_back('{IDLE, ex(2'b00, 2'b00, NRM)});
        foreach (rows[i]) begin
            @(posedge clk); #1;
            apply(rows[i].s);
            sb.push_back('{$sformatf("load_use[%0d]", i), rows[i].e});
            note(rows[i].e);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.v) begin
                errors++;
                $display("FAIL %s got %b exp %b", e.name, obs(), e.v);
            end
        end
        xs = PERF ? 16'(exp_stall) : 16'd0;
        checks++;
        if (bus.stall_cnt !== xs) begin
            errors++;
            $display("FAIL stall_cnt_lu got %0d exp %0d", bus.stall_cnt, xs);
        end
    endtask

    task automatic test_branch();
        row_t rows[$];
        exp_t e;
        logic [15:0] xf;
        rows.push_back('{st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), ex(2'b00, 2'b00, BRF)});
        rows.push_back('{st(1, 2, 0, 0, 2, 1, 1, 0, 0, 0, 0), ex(2'b00, 2'b00, NRM)});
        rows.push_back('{IDLE, ex(2'b01, 2'b00, NRM)});
        rows.push_back('{IDLE, ex(2'b00, 2'b00, NRM)});
        rows.push_back('{st(1, 2, 0, 0, 2, 1, 1, 0, 0, 0, 0), ex(2'b00, 2'b00, LU)});
        rows.push_back('{st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), ex(2'b00, 2'b00, BRF)});
        rows.push_back('{IDLE, ex(2'b00, 2'b00, NRM)});
        rows.push_back('{IDLE, ex(2'b00, 2'b00, NRM)});
        foreach (rows[i]) begin
            @(posedge clk); #1;
            apply(rows[i].s);
            sb.push_back('{$sformatf("branch[%0d]", i), rows[i].e});
            note(rows[i].e);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.v) begin
                errors++;
                $display("FAIL %s got %b exp %b", e.name, obs(), e.v);
            end
        end
        xf = PERF ? 16'(exp_flush) : 16'd0;
        checks++;
        if (bus.flush_cnt !== xf) begin
            errors++;
            $display("FAIL flush_cnt_br got %0d exp %0d", bus.flush_cnt, xf);
        end
    endtask

    task automatic test_mem_wait();
        row_t rows[$];
        exp_t e;
        logic [15:0] xs;
        logic [15:0] xf;
        rows.push_back('{st(1, 3, 0, 0, 3, 1, 0, 0, 0, 0, 0), ex(2'b00, 2'b00, NRM)});
        rows.push_back('{st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), ex(2'b01, 2'b00, FRZ)});
        rows.push_back('{st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), ex(2'b01, 2'b00, FRZ)});
        rows.push_back('{st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), ex(2'b01, 2'b00, FRZ)});
        rows.push_back('{IDLE, ex(2'b01, 2'b00, NRM)});
        rows.push_back('{IDLE, ex(2'b00, 2'b00, BRF)});
        rows.push_back('{IDLE, ex(2'b00, 2'b00, NRM)});
        rows.push_back('{IDLE, ex(2'b00, 2'b00, NRM)});
        foreach (rows[i]) begin
            @(posedge clk); #1;
            apply(rows[i].s);
            sb.push_back('{$sformatf("mem_wait[%0d]", i), rows[i].e});
            note(rows[i].e);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.v) begin
                errors++;
                $display("FAIL %s got %b exp %b", e.name, obs(), e.v);
            end
        end
        xs = PERF ? 16'(exp_stall) : 16'd0;
        xf = PERF ? 16'(exp_flush) : 16'd0;
        checks++;
        if ({bus.stall_cnt, bus.flush_cnt} !== {xs, xf}) begin
            errors++;
            $display("FAIL cnt_mw got %0d/%0d exp %0d/%0d", bus.stall_cnt, bus.flush_cnt, xs, xf);
        end
    endtask

    task automatic test_r0();
        row_t rows[$];
        exp_t e;
        rows.push_back('{st(1, 0, 0, 1, 0, 1, 1, 0, 1, 0, 0), ex(2'b00, 2'b00, NRM)});
        rows.push_back('{IDLE, ex(2'b00, 2'b00, NRM)});
        foreach (rows[i]) begin
            @(posedge clk); #1;
            apply(rows[i].s);
            sb.push_back('{$sformatf("r0[%0d]", i), rows[i].e});
            note(rows[i].e);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.v) begin
                errors++;
                $display("FAIL %s got %b exp %b", e.name, obs(), e.v);
            end
        end
    endtask

    task automatic test_reset_mid();
        row_t rows[$];
        exp_t e;
        rows.push_back('{st(1, 3, 0, 0, 3, 1, 0, 0, 0, 0, 0), ex(2'b00, 2'b00, NRM)});
        rows.push_back('{st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), ex(2'b01, 2'b00, FRZ)});
        rows.push_back('{st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), ex(2'b01, 2'b00, FRZ)});
        // reset lands mid-cycle while frozen with a branch pending
        rows.push_back('{st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), ex(2'b00, 2'b00, NRM)});
        rows.push_back('{st(1, 2, 0, 0, 2, 1, 1, 0, 0, 0, 0), ex(2'b00, 2'b00, LU)});
        rows.push_back('{IDLE, ex(2'b00, 2'b00, NRM)});
        rows.push_back('{st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), ex(2'b00, 2'b00, FRZ)});
        rows.push_back('{IDLE, ex(2'b00, 2'b00, NRM)});
        rows.push_back('{IDLE, ex(2'b00, 2'b00, NRM)});
        rows.push_back('{IDLE, ex(2'b00, 2'b00, NRM)});
        foreach (rows[i]) begin
            if (i == 3) begin
                #2;
                rst = 1'b0;
                #1;
                exp_stall = 0;
                exp_flush = 0;
            end else begin
                @(posedge clk); #1;
                apply(rows[i].s);
            end
            sb.push_back('{$sformatf("reset_mid[%0d]", i), rows[i].e});
            if (i != 3) note(rows[i].e);
            if (i != 3) @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.v) begin
                errors++;
                $display("FAIL %s got %b exp %b", e.name, obs(), e.v);
            end
            if (i == 3) begin
                checks++;
                if ({bus.stall_cnt, bus.flush_cnt} !== 32'd0) begin
                    errors++;
                    $display("FAIL reset_mid_cnt got %h exp 0", {bus.stall_cnt, bus.flush_cnt});
                end
                apply(IDLE);
                @(negedge clk);
                rst = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_fwd_ex();
        test_fwd_priority();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_r0();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
